// File: rtl/match_filter_ctrl_pkg.sv
// Shared match-filter definitions: controller state encoding, parameter defaults
// and bus widths.
package match_filter_ctrl_pkg;

  localparam int unsigned NCOEF_DEF           = 7;
  localparam int unsigned SETTLE_STROBES_DEF  = 16;
  localparam int unsigned HOLDOFF_STROBES_DEF = 8;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_ARMED,
    S_HOLDOFF
  } mf_state_e;

  // The width needed to count up to the larger of the two strobe limits.
  function automatic int unsigned strobe_cnt_w(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/match_filter_ctrl_if.sv
// Host-configuration and filter-side signals of the match filter controller.
interface match_filter_ctrl_if;

  logic                                       cfg_we;
  logic [match_filter_ctrl_pkg::ADDR_W-1:0]   cfg_addr;
  logic [match_filter_ctrl_pkg::DATA_W-1:0]   cfg_data;
  logic                                       commit;
  logic                                       clear_count;
  logic                                       rxstrobe;
  logic                                       match;
  logic                                       valid;
  logic [match_filter_ctrl_pkg::DATA_W-1:0]   cdata;
  logic [match_filter_ctrl_pkg::ADDR_W-1:0]   cstate;
  logic                                       cwrite;
  logic                                       busy;
  logic                                       armed;
  logic                                       match_pulse;
  logic [match_filter_ctrl_pkg::COUNT_W-1:0]  match_count;
  logic                                       cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, commit, clear_count, rxstrobe, match, valid,
    input  cdata, cstate, cwrite, busy, armed, match_pulse, match_count, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, commit, clear_count, rxstrobe, match, valid,
    output cdata, cstate, cwrite, busy, armed, match_pulse, match_count, cfg_err
  );

endinterface

// File: rtl/mf_coeff_bank.sv
// Shadow coefficient bank: one synchronous write port, one combinational read port.
module mf_coeff_bank
  import match_filter_ctrl_pkg::*;
#(
  parameter int unsigned NCOEF = NCOEF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Word 0 and words above NCOEF are never written, so reading them yields zero.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (we && (waddr != '0) && ({1'b0, waddr} <= (ADDR_W + 1)'(NCOEF))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/match_filter_ctrl.sv
// Match filter controller: loads the shadow coefficients into the filter, waits for
// the pipeline to settle, then counts qualified matches with a strobe-based holdoff.
module match_filter_ctrl
  import match_filter_ctrl_pkg::*;
#(
  parameter int unsigned NCOEF           = NCOEF_DEF,
  parameter int unsigned SETTLE_STROBES  = SETTLE_STROBES_DEF,
  parameter int unsigned HOLDOFF_STROBES = HOLDOFF_STROBES_DEF
) (
  input logic               clk,
  input logic               reset,
  match_filter_ctrl_if.slave bus
);

  localparam int unsigned CW = strobe_cnt_w(SETTLE_STROBES, HOLDOFF_STROBES);

  mf_state_e          state;
  logic [ADDR_W-1:0]  cstate_q;
  logic               cwrite_q;
  logic               busy_q;
  logic               armed_q;
  logic               pulse_q;
  logic               err_q;
  logic [COUNT_W-1:0] count_q;
  logic [CW-1:0]      strb_cnt;
  logic [DATA_W-1:0]  rd_data;

  logic addr_ok;
  logic cfg_open;
  logic shadow_we;
  logic hit;
  logic settle_last;
  logic hold_last;

  assign addr_ok     = (bus.cfg_addr != '0) && ({1'b0, bus.cfg_addr} <= (ADDR_W + 1)'(NCOEF));
  assign cfg_open    = (state != S_LOAD) && (state != S_SETTLE);
  assign shadow_we   = bus.cfg_we && addr_ok && cfg_open;
  // A commit in the same cycle takes precedence, so such a match is never counted.
  assign hit         = (state == S_ARMED) && bus.match && bus.valid && !bus.commit;
  assign settle_last = (strb_cnt == CW'(SETTLE_STROBES - 1));
  assign hold_last   = (strb_cnt == CW'(HOLDOFF_STROBES - 1));

  mf_coeff_bank #(
    .NCOEF (NCOEF)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (shadow_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (cstate_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cstate_q <= '0;
      cwrite_q <= 1'b0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
      strb_cnt <= '0;
    end else begin
      pulse_q <= hit;
      if (bus.cfg_we && !(addr_ok && cfg_open)) begin
        err_q <= 1'b1;
      end
      if (bus.clear_count) begin
        count_q <= '0;
      end else if (hit && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end

      // Commit from any non-busy state is hoisted out of the per-state branches.
      if (cfg_open && bus.commit) begin
        state    <= S_LOAD;
        cstate_q <= ADDR_W'(1);
        cwrite_q <= 1'b1;
        busy_q   <= 1'b1;
        armed_q  <= 1'b0;
        strb_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_LOAD: begin
            if (cstate_q == ADDR_W'(NCOEF)) begin
              state    <= S_SETTLE;
              cstate_q <= '0;
              cwrite_q <= 1'b0;
              strb_cnt <= '0;
            end else begin
              cstate_q <= cstate_q + ADDR_W'(1);
            end
          end
          S_SETTLE: begin
            if (bus.rxstrobe) begin
              if (settle_last) begin
                state    <= S_ARMED;
                busy_q   <= 1'b0;
                armed_q  <= 1'b1;
                strb_cnt <= '0;
              end else begin
                strb_cnt <= strb_cnt + CW'(1);
              end
            end
          end
          S_ARMED: begin
            if (bus.match && bus.valid) begin
              state    <= S_HOLDOFF;
              armed_q  <= 1'b0;
              strb_cnt <= '0;
            end
          end
          S_HOLDOFF: begin
            if (bus.rxstrobe) begin
              if (hold_last) begin
                state    <= S_ARMED;
                armed_q  <= 1'b1;
                strb_cnt <= '0;
              end else begin
                strb_cnt <= strb_cnt + CW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cdata       = rd_data;
  assign bus.cstate      = cstate_q;
  assign bus.cwrite      = cwrite_q;
  assign bus.busy        = busy_q;
  assign bus.armed       = armed_q;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = count_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_match_filter_ctrl.sv
// Bench for match_filter_ctrl: directed scenarios plus random traffic, all checked
// against a behavioural model of the controller kept in this file.
module tb_match_filter_ctrl;

  localparam int unsigned NC = 7;
  localparam int unsigned SS = 16;
  localparam int unsigned HS = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  match_filter_ctrl_if bus ();

  match_filter_ctrl #(
    .NCOEF           (NC),
    .SETTLE_STROBES  (SS),
    .HOLDOFF_STROBES (HS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: load word in progress (0 = none), strobes seen while settling or holding off.
  logic [31:0] m_shadow [8];
  logic [2:0]  m_load;
  bit          m_settle, m_armed, m_hold, m_pulse, m_err;
  int          m_scnt, m_hcnt;
  logic [15:0] m_count;

  logic [55:0] act;
  assign act = {bus.cdata, bus.cstate, bus.cwrite, bus.busy, bus.armed,
                bus.match_pulse, bus.match_count, bus.cfg_err};

  function automatic logic [55:0] exp_vec();
    logic [31:0] d;
    d = (m_load != 0) ? m_shadow[m_load] : 32'h0;
    return {d, m_load, (m_load != 0), ((m_load != 0) || m_settle), m_armed,
            m_pulse, m_count, m_err};
  endfunction

  task automatic model_reset();
    foreach (m_shadow[i]) m_shadow[i] = '0;
    m_load = '0; m_settle = 0; m_armed = 0; m_hold = 0; m_pulse = 0; m_err = 0;
    m_scnt = 0; m_hcnt = 0; m_count = '0;
  endtask

  task automatic model_step();
    bit busy_now, counted;
    if (!reset) begin
      model_reset();
      return;
    end
    busy_now = (m_load != 0) || m_settle;
    counted  = m_armed && bus.match && bus.valid && !bus.commit;
    if (bus.cfg_we) begin
      if (bus.cfg_addr == 0 || bus.cfg_addr > NC || busy_now) m_err = 1;
      else m_shadow[bus.cfg_addr] = bus.cfg_data;
    end
    m_pulse = counted;
    if (bus.clear_count) m_count = '0;
    else if (counted && m_count != 16'hFFFF) m_count++;
    if (!busy_now && bus.commit) begin
      m_load = 1; m_armed = 0; m_hold = 0;
    end else if (m_load != 0) begin
      if (m_load == NC) begin m_load = 0; m_settle = 1; m_scnt = 0; end
      else m_load++;
    end else if (m_settle) begin
      if (bus.rxstrobe) begin
        m_scnt++;
        if (m_scnt == SS) begin m_settle = 0; m_armed = 1; end
      end
    end else if (m_armed) begin
      if (bus.match && bus.valid) begin m_armed = 0; m_hold = 1; m_hcnt = 0; end
    end else if (m_hold && bus.rxstrobe) begin
      m_hcnt++;
      if (m_hcnt == HS) begin m_hold = 0; m_armed = 1; end
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.commit = 0;
    bus.clear_count = 0; bus.rxstrobe = 0; bus.match = 0; bus.valid = 0;
  endtask

  // One clock: inputs were set after the previous falling edge; outputs are read at the next one.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic strobe_until_armed();
    for (int k = 0; k < 64 && bus.armed !== 1'b1; k++) begin
      bus.rxstrobe = 1; tick(); bus.rxstrobe = 0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #1 reset = 0;
    #1;
    checks++;
    if (act !== 56'h0) begin errors++; $display("FAIL reset_async: got %h want %h", act, 56'h0); end
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      bus.rxstrobe = 1; bus.match = 1; bus.valid = 1;
      tick();
      checks++;
      if (act !== exp_vec() || bus.busy !== 1'b0 || bus.armed !== 1'b0) begin
        errors++; $display("FAIL reset_idle%0d: got %h want %h", i, act, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_load();
    int armed_at = -1;
    for (int i = 1; i <= 7; i++) begin
      bus.cfg_we = 1; bus.cfg_addr = 3'(i); bus.cfg_data = 32'(i) * 32'h0001_0001;
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL load_wr%0d: got %h want %h", i, act, exp_vec()); end
    end
    bus.cfg_we = 0;
    bus.commit = 1; tick(); bus.commit = 0;
    for (int k = 0; k < 400; k++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL load_c%0d: got %h want %h", k, act, exp_vec()); end
      if (k < 7) begin
        checks++;
        if ({bus.cwrite, bus.busy, bus.cstate, bus.cdata} !== {1'b1, 1'b1, 3'(k + 1), 32'(k + 1) * 32'h0001_0001}) begin
          errors++; $display("FAIL load_word%0d: got %h/%h want %h/%h", k + 1, bus.cstate, bus.cdata, 3'(k + 1), 32'(k + 1) * 32'h0001_0001);
        end
      end
      if (k == 7) begin
        checks++;
        if ({bus.cwrite, bus.cstate, bus.cdata, bus.busy} !== {1'b0, 3'd0, 32'd0, 1'b1}) begin
          errors++; $display("FAIL load_settle_entry: got %h want busy with zero bus", act);
        end
      end
      if (bus.armed === 1'b1) begin armed_at = k; break; end
      bus.rxstrobe = ((k + 1) % 16 == 0); tick(); bus.rxstrobe = 0;
    end
    // Strobe every 16 cycles; settling starts before the first strobe, so arming follows the 16th.
    checks++;
    if (armed_at != int'(16 * SS)) begin errors++; $display("FAIL load_latency: got %0d want %0d", armed_at, 16 * SS); end
  endtask

  task automatic test_holdoff();
    int pulses = 0;
    int sn = 0;
    for (int t = 1; t <= 56; t++) begin
      bus.rxstrobe = (t % 4 == 0);
      if (bus.rxstrobe) sn++;
      bus.match = bus.rxstrobe && (sn == 3 || sn == 5 || sn == 13);
      bus.valid = bus.match;
      tick();
      idle_inputs();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL holdoff_c%0d: got %h want %h", t, act, exp_vec()); end
      if (bus.match_pulse === 1'b1) pulses++;
      if (t == 24) begin
        checks++;
        if (bus.match_count !== 16'd1) begin errors++; $display("FAIL holdoff_suppress: got %0d want 1", bus.match_count); end
      end
    end
    checks++;
    if (pulses != 2 || bus.match_count !== 16'd2) begin
      errors++; $display("FAIL holdoff_total: got pulses=%0d count=%0d want 2/2", pulses, bus.match_count);
    end
  endtask

  task automatic test_saturate();
    strobe_until_armed();
    force dut.count_q = 16'hFFFE;
    #1 release dut.count_q;
    m_count = 16'hFFFE;
    for (int m = 0; m < 3; m++) begin
      strobe_until_armed();
      checks++;
      if (bus.armed !== 1'b1) begin errors++; $display("FAIL sat_arm%0d: got armed=%b want 1", m, bus.armed); end
      bus.match = 1; bus.valid = 1; tick(); idle_inputs();
      checks++;
      if (act !== exp_vec() || bus.match_pulse !== 1'b1) begin
        errors++; $display("FAIL sat_match%0d: got %h want %h", m, act, exp_vec());
      end
    end
    checks++;
    if (bus.match_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.match_count); end
    strobe_until_armed();
    bus.clear_count = 1; bus.match = 1; bus.valid = 1; tick(); idle_inputs();
    checks++;
    if ({bus.match_pulse, bus.match_count} !== {1'b1, 16'h0} || act !== exp_vec()) begin
      errors++; $display("FAIL sat_clear: got pulse=%b count=%h want 1/0000", bus.match_pulse, bus.match_count);
    end
  endtask

  task automatic test_commit_vs_match();
    strobe_until_armed();
    bus.commit = 1; bus.match = 1; bus.valid = 1; tick(); idle_inputs();
    checks++;
    if ({bus.match_pulse, bus.cwrite, bus.cstate, bus.busy, bus.armed, bus.match_count} !==
        {1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL commit_wins: got %h want load entry with no pulse", act);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL commit_load_c%0d: got %h want %h", k, act, exp_vec()); end
    end
  endtask

  task automatic test_cfg_err();
    reset = 0; tick(); reset = 1;
    for (int i = 1; i <= 7; i++) begin
      bus.cfg_we = 1; bus.cfg_addr = 3'(i); bus.cfg_data = $urandom(); tick();
    end
    bus.cfg_we = 1; bus.cfg_addr = 3'd0; bus.cfg_data = $urandom(); tick(); idle_inputs();
    checks++;
    if (bus.cfg_err !== 1'b1 || act !== exp_vec()) begin
      errors++; $display("FAIL cfg_addr0: got %h want %h", act, exp_vec());
    end
    bus.commit = 1; tick(); bus.commit = 0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL cfg_busy_c%0d: got %h want %h", k, act, exp_vec()); end
      if (k == 1) begin bus.cfg_we = 1; bus.cfg_addr = 3'd3; bus.cfg_data = $urandom(); end
      if (k == 8) begin bus.cfg_we = 1; bus.cfg_addr = 3'd5; bus.cfg_data = $urandom(); end
      tick();
      bus.cfg_we = 0;
    end
    checks++;
    if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_sticky: got %b want 1", bus.cfg_err); end
  endtask

  task automatic test_reset_mid_load();
    reset = 0; tick(); reset = 1;
    checks++;
    if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", bus.cfg_err); end
    for (int i = 1; i <= 7; i++) begin
      bus.cfg_we = 1; bus.cfg_addr = 3'(i); bus.cfg_data = $urandom(); tick();
    end
    bus.cfg_we = 0;
    bus.commit = 1; tick(); bus.commit = 0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (bus.cstate !== 3'd4 || bus.cwrite !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got cstate=%0d cwrite=%b want 4/1", bus.cstate, bus.cwrite);
    end
    reset = 0;
    #1;
    model_reset();
    checks++;
    if (act !== 56'h0) begin errors++; $display("FAIL abort_async: got %h want %h", act, 56'h0); end
    tick(); tick();
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (act !== exp_vec() || bus.cwrite !== 1'b0) begin
        errors++; $display("FAIL abort_idle%0d: got %h want %h", k, act, exp_vec());
      end
    end
    for (int i = 1; i <= 7; i++) begin
      bus.cfg_we = 1; bus.cfg_addr = 3'(i); bus.cfg_data = $urandom(); tick();
    end
    bus.cfg_we = 0;
    bus.commit = 1; tick(); bus.commit = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (act !== exp_vec() || (k < 7 && bus.cstate !== 3'(k + 1))) begin
        errors++; $display("FAIL reload_c%0d: got %h want %h", k, act, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    reset = 0; tick(); reset = 1;
    for (int c = 0; c < 3000; c++) begin
      bus.cfg_we      = ($urandom_range(0, 7) == 0);
      bus.cfg_addr    = 3'($urandom_range(0, 7));
      bus.cfg_data    = $urandom();
      bus.commit      = ($urandom_range(0, 63) == 0);
      bus.clear_count = ($urandom_range(0, 127) == 0);
      bus.rxstrobe    = ($urandom_range(0, 1) == 0);
      bus.match       = ($urandom_range(0, 3) == 0);
      bus.valid       = ($urandom_range(0, 1) == 0);
      tick();
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h want %h", c, act, exp_vec()); end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_load();
    test_holdoff();
    test_saturate();
    test_commit_vs_match();
    test_cfg_err();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
